// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared state codes, effect ids, note type and effect ROM
// Purpose: common definitions for the sound sequencer and its tone generator.
// Ports:   none (package).
package sound_pkg;

   localparam int NREQ = 4;

   // FSM state encoding
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_PLAY = 2'd2;

   // Effect ids; a lower id has higher priority
   localparam logic [1:0] ID_GAME_OVER  = 2'd0;
   localparam logic [1:0] ID_LINE_CLEAR = 2'd1;
   localparam logic [1:0] ID_LOCK       = 2'd2;
   localparam logic [1:0] ID_MOVE       = 2'd3;

   // Index one past the last ROM slot; reaching it ends an effect with no end marker
   localparam logic [2:0] IDX_END = 3'd4;

   typedef struct packed {
      logic [15:0] half;  // half-period in clock cycles, 0 = rest
      logic [7:0]  dur;   // duration in ticks, 0 = end of effect
   } note_t;

   // Effect ROM, ROM[id][idx]; rows listed from id 3 down to id 0, notes from idx 3 down to 0
   localparam logic [3:0][3:0][23:0] ROM = {
      {24'd0, 24'd0, 24'd0, {16'd12500, 8'd2}},
      {24'd0, 24'd0, 24'd0, {16'd62500, 8'd3}},
      {{16'd11939, 8'd10}, {16'd15944, 8'd5}, {16'd18968, 8'd5}, {16'd23901, 8'd5}},
      {24'd0, {16'd47710, 8'd40}, {16'd37879, 8'd20}, {16'd31888, 8'd20}}
   };

   // Lowest set index of a request vector (0 when empty; qualify with |v)
   function automatic logic [1:0] first_set(input logic [NREQ-1:0] v);
      first_set = 2'd0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (v[i]) first_set = 2'(i);
      end
   endfunction

endpackage

// File: rtl/sound_sequencer_if.sv
// rtl/sound_sequencer_if.sv - request/status bundle between game logic and the sound sequencer
// Purpose: groups the sequencer's request inputs and speaker/status outputs.
// Signals: req (request pulses), mute, busy, active_id, half_period, tone_on, speaker0, speaker1.
// Modports: master = game logic side, slave = sequencer side.
interface sound_sequencer_if;
   import sound_pkg::*;

   logic [NREQ-1:0] req;
   logic            mute;
   logic            busy;
   logic [1:0]      active_id;
   logic [15:0]     half_period;
   logic            tone_on;
   logic            speaker0;
   logic            speaker1;

   modport master (
      output req, mute,
      input  busy, active_id, half_period, tone_on, speaker0, speaker1
   );

   modport slave (
      input  req, mute,
      output busy, active_id, half_period, tone_on, speaker0, speaker1
   );
endinterface

// File: rtl/sound_tone.sv
// rtl/sound_tone.sv - square-wave tone generator driving the speaker pair
// Purpose: toggles a square wave every half_period_i cycles while a note sounds.
// Ports:   clk_i, rst_i (sync, active-high); half_period_i, tone_on_i, mute_i in;
//          speaker0_o, speaker1_o out (both 0 when silent or muted).
module sound_tone (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] half_period_i,
   input  logic        tone_on_i,
   input  logic        mute_i,
   output logic        speaker0_o,
   output logic        speaker1_o
);
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] last_q;
   logic        s_q, s_d;

   always_comb begin
      cnt_d = cnt_q + 16'd1;
      s_d   = s_q;
      // A new note always starts from phase 0, so restart on any half-period change
      if (!tone_on_i || half_period_i == 16'd0 || half_period_i != last_q) begin
         cnt_d = 16'd0;
         s_d   = 1'b0;
      end else if (cnt_q == half_period_i - 16'd1) begin
         cnt_d = 16'd0;
         s_d   = ~s_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= 16'd0;
         s_q    <= 1'b0;
         last_q <= 16'd0;
      end else begin
         cnt_q  <= cnt_d;
         s_q    <= s_d;
         last_q <= half_period_i;
      end
   end

   assign speaker0_o = s_q & tone_on_i & ~mute_i;
   assign speaker1_o = ~s_q & tone_on_i & ~mute_i;
endmodule

// File: rtl/sound_sequencer.sv
// rtl/sound_sequencer.sv - prioritised sound-effect sequencer for the speaker pair
// Purpose: latches effect requests, grants the highest-priority one, steps its ROM notes
//          and feeds the tone generator; a higher-priority request preempts a playing effect.
// Ports:   clk_i, rst_i (sync, active-high); bus (slave): req, mute in;
//          busy, active_id, half_period, tone_on, speaker0, speaker1 out.
module sound_sequencer
   import sound_pkg::*;
#(
   parameter int unsigned TICK_DIV = 250000
) (
   input logic               clk_i,
   input logic               rst_i,
   sound_sequencer_if.slave  bus
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [1:0]      state_q, state_d;
   logic [NREQ-1:0] pend_q, pend_d, clr;
   logic [1:0]      id_q, id_d;
   logic [2:0]      idx_q, idx_d;
   logic [15:0]     half_q, half_d;
   logic            tone_q, tone_d;
   logic [7:0]      tick_q, tick_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [1:0]      gnt_id;
   logic            gnt_vld, preempt;
   note_t           note;

   assign gnt_vld = |pend_q;
   assign gnt_id  = first_set(pend_q);
   assign preempt = (state_q != S_IDLE) && gnt_vld && (gnt_id < id_q);
   assign note    = ROM[id_q][idx_q[1:0]];

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      idx_d   = idx_q;
      half_d  = half_q;
      tone_d  = tone_q;
      tick_d  = tick_q;
      presc_d = presc_q;
      clr     = '0;

      // Grant from IDLE and preemption share one path: the old effect is simply dropped
      if ((state_q == S_IDLE && gnt_vld) || preempt) begin
         state_d     = S_LOAD;
         id_d        = gnt_id;
         idx_d       = 3'd0;
         clr[gnt_id] = 1'b1;
      end else if (state_q == S_LOAD) begin
         if (idx_q == IDX_END || note.dur == 8'd0) begin
            state_d = S_IDLE;
            id_d    = 2'd0;
            half_d  = 16'd0;
            tone_d  = 1'b0;
         end else begin
            state_d = S_PLAY;
            half_d  = note.half;
            tone_d  = (note.half != 16'd0);
            tick_d  = note.dur;
            presc_d = '0;
         end
      end else if (state_q == S_PLAY) begin
         if (presc_q == PW'(TICK_DIV - 1)) begin
            presc_d = '0;
            tick_d  = tick_q - 8'd1;
            if (tick_q == 8'd1) begin
               idx_d   = idx_q + 3'd1;
               state_d = S_LOAD;
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end

      // A new request on the clearing edge must not be lost
      pend_d = (pend_q & ~clr) | bus.req;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         pend_q  <= '0;
         id_q    <= 2'd0;
         idx_q   <= 3'd0;
         half_q  <= 16'd0;
         tone_q  <= 1'b0;
         tick_q  <= 8'd0;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         id_q    <= id_d;
         idx_q   <= idx_d;
         half_q  <= half_d;
         tone_q  <= tone_d;
         tick_q  <= tick_d;
         presc_q <= presc_d;
      end
   end

   assign bus.busy        = (state_q != S_IDLE);
   assign bus.active_id   = id_q;
   assign bus.half_period = half_q;
   assign bus.tone_on     = tone_q;

   sound_tone u_tone (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .half_period_i (half_q),
      .tone_on_i     (tone_q),
      .mute_i        (bus.mute),
      .speaker0_o    (bus.speaker0),
      .speaker1_o    (bus.speaker1)
   );
endmodule

// File: tb/tb_sound_sequencer.sv
// tb/tb_sound_sequencer.sv - directed self-checking bench for sound_sequencer
module tb_sound_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] t_half = 16'd0;
   logic        t_on = 1'b0;
   logic        t_mute = 1'b0;
   logic        t_s0, t_s1;
   int          errors = 0;
   int          checks = 0;

   sound_sequencer_if bus ();

   sound_sequencer #(.TICK_DIV(10)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   sound_tone u_tone (
      .clk_i         (clk),
      .rst_i         (rst),
      .half_period_i (t_half),
      .tone_on_i     (t_on),
      .mute_i        (t_mute),
      .speaker0_o    (t_s0),
      .speaker1_o    (t_s1)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [3:0] r);
      bus.req = r;
      step();
      bus.req = 4'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req = 4'd0;
      bus.mute = 1'b0;
      step();
      step();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.active_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", bus.active_id); end
      checks++; if (bus.half_period !== 16'd0) begin errors++; $display("FAIL reset_half: got %0d expected 0", bus.half_period); end
      checks++; if (bus.tone_on !== 1'b0) begin errors++; $display("FAIL reset_tone: got %b expected 0", bus.tone_on); end
      checks++; if ({bus.speaker0, bus.speaker1} !== 2'b00) begin errors++; $display("FAIL reset_spk: got %b expected 00", {bus.speaker0, bus.speaker1}); end
      rst = 1'b0;
      step();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got %b expected 0", bus.busy); end
   endtask

   task automatic test_single_effect();
      int n;
      pulse(4'b1000);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_edge1_busy: got %b expected 0", bus.busy); end
      step();
      checks++; if (bus.busy !== 1'b1 || bus.active_id !== 2'd3) begin errors++; $display("FAIL single_edge2: busy=%b id=%0d expected busy=1 id=3", bus.busy, bus.active_id); end
      checks++; if (bus.half_period !== 16'd0) begin errors++; $display("FAIL single_edge2_half: got %0d expected 0", bus.half_period); end
      step();
      checks++; if (bus.half_period !== 16'd12500 || bus.tone_on !== 1'b1) begin errors++; $display("FAIL single_edge3: half=%0d tone=%b expected 12500 1", bus.half_period, bus.tone_on); end
      checks++; if ({bus.speaker0, bus.speaker1} !== 2'b01) begin errors++; $display("FAIL single_spk: got %b expected 01", {bus.speaker0, bus.speaker1}); end
      n = 2;
      for (int i = 0; i < 200; i++) begin
         step();
         if (!bus.busy) break;
         n++;
      end
      checks++; if (n !== 22) begin errors++; $display("FAIL single_busy_len: got %0d expected 22", n); end
      checks++; if ({bus.busy, bus.active_id, bus.half_period, bus.tone_on, bus.speaker0, bus.speaker1} !== 22'd0) begin
         errors++; $display("FAIL single_end_outputs: busy=%b id=%0d half=%0d tone=%b expected all 0", bus.busy, bus.active_id, bus.half_period, bus.tone_on);
      end
   endtask

   task automatic test_priority_queue();
      int n, k;
      logic bad;
      logic [15:0] last;
      logic [15:0] seq [4];
      pulse(4'b0110);
      step();
      checks++; if (bus.busy !== 1'b1 || bus.active_id !== 2'd1) begin errors++; $display("FAIL prio_first: busy=%b id=%0d expected 1 1", bus.busy, bus.active_id); end
      n = 1; k = 0; bad = 1'b0; last = 16'd0;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (!bus.busy) break;
         n++;
         if (bus.active_id !== 2'd1) bad = 1'b1;
         if (bus.half_period != last && bus.half_period != 16'd0) begin
            if (k < 4) seq[k] = bus.half_period;
            k++;
            last = bus.half_period;
         end
      end
      checks++; if (n !== 255) begin errors++; $display("FAIL prio_id1_len: got %0d expected 255", n); end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL prio_id1_interrupted: got %b expected 0", bad); end
      checks++; if (k !== 4) begin errors++; $display("FAIL prio_note_count: got %0d expected 4", k); end
      checks++; if (k == 4 && (seq[0] !== 16'd23901 || seq[1] !== 16'd18968 || seq[2] !== 16'd15944 || seq[3] !== 16'd11939)) begin
         errors++; $display("FAIL prio_note_seq: got %0d %0d %0d %0d expected 23901 18968 15944 11939", seq[0], seq[1], seq[2], seq[3]);
      end
      checks++; if (bus.busy !== 1'b0 || bus.half_period !== 16'd0) begin errors++; $display("FAIL prio_gap: busy=%b half=%0d expected 0 0", bus.busy, bus.half_period); end
      step();
      checks++; if (bus.busy !== 1'b1 || bus.active_id !== 2'd2) begin errors++; $display("FAIL prio_id2_start: busy=%b id=%0d expected 1 2", bus.busy, bus.active_id); end
      step();
      checks++; if (bus.half_period !== 16'd62500) begin errors++; $display("FAIL prio_id2_half: got %0d expected 62500", bus.half_period); end
      for (int i = 0; i < 100; i++) begin
         step();
         if (!bus.busy) break;
      end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL prio_id2_end: got busy=%b expected 0", bus.busy); end
   endtask

   task automatic test_preempt();
      logic bad;
      pulse(4'b1000);
      step();
      step();
      pulse(4'b0001);
      checks++; if (bus.active_id !== 2'd3) begin errors++; $display("FAIL preempt_before: got %0d expected 3", bus.active_id); end
      step();
      checks++; if (bus.active_id !== 2'd0 || bus.busy !== 1'b1) begin errors++; $display("FAIL preempt_id: id=%0d busy=%b expected 0 1", bus.active_id, bus.busy); end
      step();
      checks++; if (bus.half_period !== 16'd31888) begin errors++; $display("FAIL preempt_half: got %0d expected 31888", bus.half_period); end
      bad = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         step();
         if (!bus.busy) break;
         if (bus.active_id !== 2'd0) bad = 1'b1;
      end
      checks++; if (bus.busy !== 1'b0 || bad !== 1'b0) begin errors++; $display("FAIL preempt_id0_run: busy=%b other_id=%b expected 0 0", bus.busy, bad); end
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.busy) bad = 1'b1;
      end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL preempt_resumed: got %b expected 0", bad); end
   endtask

   task automatic test_coalesce();
      int starts;
      logic cur, prev;
      pulse(4'b0010);
      for (int p = 0; p < 5; p++) begin
         repeat (3) step();
         pulse(4'b1000);
      end
      checks++; if (bus.active_id !== 2'd1) begin errors++; $display("FAIL coalesce_id1: got %0d expected 1", bus.active_id); end
      starts = 0; prev = 1'b0;
      for (int i = 0; i < 600; i++) begin
         step();
         cur = bus.busy && (bus.active_id == 2'd3);
         if (cur && !prev) starts++;
         prev = cur;
      end
      checks++; if (starts !== 1) begin errors++; $display("FAIL coalesce_starts: got %0d expected 1", starts); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL coalesce_idle: got %b expected 0", bus.busy); end
   endtask

   task automatic test_mute();
      pulse(4'b1000);
      step();
      step();
      bus.mute = 1'b1;
      #1;
      checks++; if ({bus.speaker0, bus.speaker1} !== 2'b00 || bus.busy !== 1'b1) begin errors++; $display("FAIL mute_spk: spk=%b busy=%b expected 00 1", {bus.speaker0, bus.speaker1}, bus.busy); end
      step();
      checks++; if (bus.busy !== 1'b1 || bus.half_period !== 16'd12500) begin errors++; $display("FAIL mute_seq: busy=%b half=%0d expected 1 12500", bus.busy, bus.half_period); end
      bus.mute = 1'b0;
      #1;
      checks++; if ({bus.speaker0, bus.speaker1} !== 2'b01) begin errors++; $display("FAIL unmute_spk: got %b expected 01", {bus.speaker0, bus.speaker1}); end
      for (int i = 0; i < 100; i++) begin
         step();
         if (!bus.busy) break;
      end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mute_end: got %b expected 0", bus.busy); end
   endtask

   task automatic test_reset_mid();
      logic bad;
      pulse(4'b0001);
      repeat (30) step();
      checks++; if (bus.busy !== 1'b1 || bus.half_period !== 16'd31888) begin errors++; $display("FAIL rstmid_playing: busy=%b half=%0d expected 1 31888", bus.busy, bus.half_period); end
      rst = 1'b1;
      bus.req = 4'b1000;
      step();
      checks++; if (bus.busy !== 1'b0 || {bus.speaker0, bus.speaker1} !== 2'b00) begin errors++; $display("FAIL rstmid_out: busy=%b spk=%b expected 0 00", bus.busy, {bus.speaker0, bus.speaker1}); end
      checks++; if (bus.half_period !== 16'd0 || bus.active_id !== 2'd0) begin errors++; $display("FAIL rstmid_regs: half=%0d id=%0d expected 0 0", bus.half_period, bus.active_id); end
      rst = 1'b0;
      bus.req = 4'd0;
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (bus.busy) bad = 1'b1;
      end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rstmid_pending: got busy after reset=%b expected 0", bad); end
   endtask

   task automatic test_tone();
      logic e;
      t_half = 16'd4;
      t_on = 1'b1;
      t_mute = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         step();
         e = ((k - 1) / 4) % 2 == 1;
         checks++; if (t_s0 !== e || t_s1 !== !e) begin errors++; $display("FAIL tone4_k%0d: s0=%b s1=%b expected %b %b", k, t_s0, t_s1, e, !e); end
      end
      t_mute = 1'b1;
      #1;
      checks++; if ({t_s0, t_s1} !== 2'b00) begin errors++; $display("FAIL tone_mute: got %b expected 00", {t_s0, t_s1}); end
      t_mute = 1'b0;
      t_half = 16'd1;
      for (int k = 1; k <= 6; k++) begin
         step();
         e = ((k - 1) % 2) == 1;
         checks++; if (t_s0 !== e || t_s1 !== !e) begin errors++; $display("FAIL tone1_k%0d: s0=%b s1=%b expected %b %b", k, t_s0, t_s1, e, !e); end
      end
      t_on = 1'b0;
      t_half = 16'd0;
      step();
      checks++; if ({t_s0, t_s1} !== 2'b00) begin errors++; $display("FAIL tone_off: got %b expected 00", {t_s0, t_s1}); end
   endtask

   initial begin
      bus.req = 4'd0;
      bus.mute = 1'b0;
      test_reset();
      test_single_effect();
      test_priority_queue();
      test_preempt();
      test_coalesce();
      test_mute();
      test_reset_mid();
      test_tone();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
